pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter generator for the RISC-V core; successor to the single-mode PC register. It selects among four next-PC sources: sequential, branch, JALR and trap/return. It also holds the exception PC, provides halt/resume control and counts retired instructions. It sits at the front of the datapath and drives the instruction-memory address.

Parameters:
XLEN, 32, datapath and address width (≥8)
RESET_VECTOR, 32'h0000_0000, PC value after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
areset  in  1  synchronous, active-high reset
load  in  1  advance enable; 0 = stall, all state held
PCSrc  in  2  next-PC select: 00 PC+4, 01 PC+ImmExt, 10 JALR, 11 reserved (treated as 00)
ImmExt  in  XLEN  sign-extended immediate from extender
rs1_val  in  XLEN  register-file rs1 value (JALR base)
trap_req  in  1  synchronous exception/ecall request
mret  in  1  return from trap
halt_req  in  1  request to stop fetching
resume  in  1  leave HALTED
PC  out  XLEN  current instruction address
PCPlus4  out  XLEN  combinational PC+4 (link value)
epc  out  XLEN  saved exception PC
trap_taken  out  1  one-cycle pulse on trap entry
misalign  out  1  one-cycle pulse; misaligned target trapped (feature only)
halted  out  1  high in HALTED
instret  out  CNT_W  retired-instruction count

Behaviour:
- All registers update on rising clk. areset dominates every other input. On reset: PC=RESET_VECTOR, epc=0, instret=0, trap_taken=0, misalign=0, halted=0, state=RUN.
- FSM states: RUN, HALTED. RUN->HALTED on load=1 and halt_req=1 when no trap_req is present; PC is frozen in HALTED. HALTED->RUN on resume=1, independent of load. In HALTED, all other inputs are ignored and instret holds.
- In RUN with load=0: PC, epc and instret hold. trap_req and mret are ignored; the source must keep them asserted until load=1.
- In RUN with load=1, priority is trap_req > mret > halt_req > PCSrc:
  - trap_req: epc<=PC; PC<=TRAP_VECTOR; trap_taken=1 next cycle; instret does not increment.
  - mret: PC<=epc; instret+1.
  - halt_req: PC holds; state<=HALTED; instret+1.
  - Otherwise the target is chosen by PCSrc: 00/11 PC+4; 01 PC+ImmExt; 10 (rs1_val+ImmExt) with bit0 cleared. PC<=target and instret+1.
- All address arithmetic is modulo 2^XLEN, so 0xFFFF_FFFC+4 wraps to 0 silently. instret wraps at 2^CNT_W.
- PCPlus4 is combinational from PC with zero latency.
- trap_taken and misalign are registered pulses, high exactly one cycle.
- Simultaneous trap_req and mret: the trap wins, and epc takes the current PC, not the old epc.

Optional Feature:
PC_MISALIGN_TRAP_EN
- Defined: any selected target with target[1:0]≠0 (after the JALR bit0 clear) is not loaded. Instead epc<=PC, PC<=TRAP_VECTOR, and misalign and trap_taken pulse. instret does not increment.
- Undefined: target[1:0] is forced to 00 and loaded normally. The misalign port is tied to 0.

Decomposition:
- Shared package rv_core_pkg holds the PCSrc encodings (PC_SEQ=2'b00, PC_BR=2'b01, PC_JALR=2'b10), the FSM state typedef (RUN, HALTED) and default vector constants.
- One sub-module, pc_target_mux: purely combinational target computation and misalignment detect, instantiated once.

Test Plan:
- Reset then load=1, PCSrc=00 for 3 cycles -> PC 0x0,0x4,0x8,0xC; instret=3.
- PC=0x10, PCSrc=01, ImmExt=0xFFFF_FFF8 -> PC=0x08. Next cycle with load=0 -> PC stays 0x08.
- PC=0x20, PCSrc=10, rs1_val=0x101, ImmExt=0x4 -> PC=0x104 (bit0 cleared). With the feature defined, rs1_val=0x102 -> PC=0x100 (TRAP_VECTOR), epc=0x20, misalign=1 for one cycle.
- PC=0x40, trap_req=1 and mret=1 together -> PC=0x100, epc=0x40, trap_taken pulses. Then mret=1 -> PC=0x40.
- halt_req at PC=0x50 -> halted=1, PC holds at 0x50 for 5 cycles despite PCSrc activity. resume=1 -> halted=0, and the next load advances PC to 0x54.
- PC=0xFFFF_FFFC, PCSrc=00 -> PC=0x0. Assert areset mid-trap cycle -> PC=RESET_VECTOR, epc=0, trap_taken=0.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared definitions for the RISC-V core front end: next-PC source
// encodings, the PC unit state type and default vector constants.
package rv_core_pkg;

    // Next-PC source select encodings (2'b11 is reserved and behaves as PC_SEQ)
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    // PC unit run/halt state
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

    // Default vectors; narrower datapaths take the low bits
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target selection and misalignment detect.
// Optional build macro: PC_MISALIGN_TRAP_EN (flag misaligned targets
// instead of forcing them to word alignment).
module pc_target_mux
    import rv_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] immext,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] raw;

    // Select the raw target, then either flag or force word alignment
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        raw      = pc_plus4;
        case (pcsrc)
            PC_BR:   raw = pc + immext;
            PC_JALR: raw = (rs1_val + immext) & ~XLEN'(1);
            default: raw = pc_plus4;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        target     = raw;
        misaligned = |raw[1:0];
`else
        target     = raw & ~XLEN'(3);
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, trap entry/return, halt/resume
// and retired-instruction counting.
// Optional build macro: PC_MISALIGN_TRAP_EN (trap on misaligned targets).
module pc_unit
    import rv_core_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic [1:0]       PCSrc,
    input  logic [XLEN-1:0]  ImmExt,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic             trap_req,
    input  logic             mret,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PCPlus4,
    output logic [XLEN-1:0]  epc,
    output logic             trap_taken,
    output logic             misalign,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    pc_state_t        state;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  epc_q;
    logic [CNT_W-1:0] instret_q;
    logic             trap_taken_q;
    logic [XLEN-1:0]  target;
    logic             target_misaligned;

    pc_target_mux #(
        .XLEN (XLEN)
    ) u_target_mux (
        .pc         (pc_q),
        .pcsrc      (PCSrc),
        .immext     (ImmExt),
        .rs1_val    (rs1_val),
        .pc_plus4   (PCPlus4),
        .target     (target),
        .misaligned (target_misaligned)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Run/halt FSM with PC, exception PC, counter and pulse registers
    always_ff @(posedge clk) begin
        if (areset) begin
            state        <= RUN;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            instret_q    <= '0;
            trap_taken_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            trap_taken_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
            case (state)
                RUN: begin
                    if (load) begin
                        if (trap_req) begin
                            epc_q        <= pc_q;
                            pc_q         <= TRAP_VECTOR;
                            trap_taken_q <= 1'b1;
                        end else if (mret) begin
                            pc_q      <= epc_q;
                            instret_q <= instret_q + CNT_W'(1);
                        end else if (halt_req) begin
                            state     <= HALTED;
                            instret_q <= instret_q + CNT_W'(1);
                        end else if (target_misaligned) begin
                            // Constant 0 unless misaligned-target trapping is built in
                            epc_q        <= pc_q;
                            pc_q         <= TRAP_VECTOR;
                            trap_taken_q <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                            misalign_q   <= 1'b1;
`endif
                        end else begin
                            pc_q      <= target;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign PC         = pc_q;
    assign epc        = epc_q;
    assign instret    = instret_q;
    assign trap_taken = trap_taken_q;
    assign halted     = (state == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
// Honours PC_MISALIGN_TRAP_EN for the misaligned JALR scenario.
module tb_pc_unit;

    logic        clk;
    logic        areset;
    logic        load;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] rs1_val;
    logic        trap_req;
    logic        mret;
    logic        halt_req;
    logic        resume;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] epc;
    logic        trap_taken;
    logic        misalign;
    logic        halted;
    logic [31:0] instret;

    int unsigned checks = 0;
    int unsigned passes = 0;
    logic [31:0] exp_instret = '0;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .CNT_W        (32)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .load       (load),
        .PCSrc      (PCSrc),
        .ImmExt     (ImmExt),
        .rs1_val    (rs1_val),
        .trap_req   (trap_req),
        .mret       (mret),
        .halt_req   (halt_req),
        .resume     (resume),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .epc        (epc),
        .trap_taken (trap_taken),
        .misalign   (misalign),
        .halted     (halted),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Jump to an aligned address via JALR with zero offset (retires one)
    task automatic set_pc(input logic [31:0] t);
        load = 1'b1; PCSrc = 2'b10; rs1_val = t; ImmExt = '0;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== t) $display("FAIL set_pc: PC=%h expected %h", PC, t);
        else passes++;
    endtask

    task automatic test_reset();
        areset = 1'b1; load = 1'b0; PCSrc = 2'b00; ImmExt = '0; rs1_val = '0;
        trap_req = 1'b0; mret = 1'b0; halt_req = 1'b0; resume = 1'b0;
        step(); step();
        checks++;
        if (PC !== 32'h0) $display("FAIL reset_pc: PC=%h expected 00000000", PC); else passes++;
        checks++;
        if (epc !== 32'h0) $display("FAIL reset_epc: epc=%h expected 00000000", epc); else passes++;
        checks++;
        if (instret !== 32'h0) $display("FAIL reset_instret: instret=%0d expected 0", instret); else passes++;
        checks++;
        if ({halted, trap_taken, misalign} !== 3'b000)
            $display("FAIL reset_flags: halted/trap/mis=%b expected 000", {halted, trap_taken, misalign});
        else passes++;
        checks++;
        if (PCPlus4 !== 32'h4) $display("FAIL reset_pcplus4: PCPlus4=%h expected 00000004", PCPlus4); else passes++;
        areset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h4; exp_seq[1] = 32'h8; exp_seq[2] = 32'hC;
        load = 1'b1; PCSrc = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_instret = exp_instret + 1;
            checks++;
            if (PC !== exp_seq[i]) $display("FAIL seq_pc[%0d]: PC=%h expected %h", i, PC, exp_seq[i]);
            else passes++;
        end
        checks++;
        if (instret !== 32'd3) $display("FAIL seq_instret: instret=%0d expected 3", instret); else passes++;
        checks++;
        if (PCPlus4 !== 32'h10) $display("FAIL seq_pcplus4: PCPlus4=%h expected 00000010", PCPlus4); else passes++;
    endtask

    task automatic test_branch();
        set_pc(32'h10);
        load = 1'b1; PCSrc = 2'b01; ImmExt = 32'hFFFF_FFF8;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h08) $display("FAIL branch_back: PC=%h expected 00000008", PC); else passes++;
        load = 1'b0;
        step();
        checks++;
        if (PC !== 32'h08) $display("FAIL stall_pc: PC=%h expected 00000008", PC); else passes++;
        checks++;
        if (instret !== exp_instret) $display("FAIL stall_instret: instret=%0d expected %0d", instret, exp_instret);
        else passes++;
        // Reserved select behaves as sequential
        load = 1'b1; PCSrc = 2'b11; ImmExt = 32'h40;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h0C) $display("FAIL reserved_sel: PC=%h expected 0000000c", PC); else passes++;
    endtask

    task automatic test_jalr();
        set_pc(32'h20);
        load = 1'b1; PCSrc = 2'b10; rs1_val = 32'h101; ImmExt = 32'h4;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h104) $display("FAIL jalr_bit0: PC=%h expected 00000104", PC); else passes++;
        set_pc(32'h20);
        load = 1'b1; PCSrc = 2'b10; rs1_val = 32'h102; ImmExt = 32'h0;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        checks++;
        if (PC !== 32'h100) $display("FAIL mis_pc: PC=%h expected 00000100", PC); else passes++;
        checks++;
        if (epc !== 32'h20) $display("FAIL mis_epc: epc=%h expected 00000020", epc); else passes++;
        checks++;
        if ({misalign, trap_taken} !== 2'b11)
            $display("FAIL mis_pulse: misalign/trap=%b expected 11", {misalign, trap_taken});
        else passes++;
        checks++;
        if (instret !== exp_instret) $display("FAIL mis_instret: instret=%0d expected %0d", instret, exp_instret);
        else passes++;
        PCSrc = 2'b00;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if ({misalign, trap_taken} !== 2'b00)
            $display("FAIL mis_pulse_end: misalign/trap=%b expected 00", {misalign, trap_taken});
        else passes++;
`else
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h100) $display("FAIL align_force: PC=%h expected 00000100", PC); else passes++;
        checks++;
        if ({misalign, trap_taken} !== 2'b00)
            $display("FAIL align_flags: misalign/trap=%b expected 00", {misalign, trap_taken});
        else passes++;
        checks++;
        if (epc !== 32'h0) $display("FAIL align_epc: epc=%h expected 00000000", epc); else passes++;
        checks++;
        if (instret !== exp_instret) $display("FAIL align_instret: instret=%0d expected %0d", instret, exp_instret);
        else passes++;
`endif
    endtask

    task automatic test_trap_mret();
        set_pc(32'h40);
        // Trap and mret held during a stall are ignored
        load = 1'b0; trap_req = 1'b1; mret = 1'b1;
        step();
        checks++;
        if (PC !== 32'h40 || trap_taken !== 1'b0)
            $display("FAIL trap_stall: PC=%h trap=%b expected 00000040/0", PC, trap_taken);
        else passes++;
        load = 1'b1;
        step();
        checks++;
        if (PC !== 32'h100) $display("FAIL trap_pc: PC=%h expected 00000100", PC); else passes++;
        checks++;
        if (epc !== 32'h40) $display("FAIL trap_epc: epc=%h expected 00000040", epc); else passes++;
        checks++;
        if (trap_taken !== 1'b1) $display("FAIL trap_pulse: trap_taken=%b expected 1", trap_taken); else passes++;
        checks++;
        if (instret !== exp_instret) $display("FAIL trap_instret: instret=%0d expected %0d", instret, exp_instret);
        else passes++;
        trap_req = 1'b0;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h40) $display("FAIL mret_pc: PC=%h expected 00000040", PC); else passes++;
        checks++;
        if (trap_taken !== 1'b0) $display("FAIL trap_pulse_end: trap_taken=%b expected 0", trap_taken); else passes++;
        checks++;
        if (instret !== exp_instret) $display("FAIL mret_instret: instret=%0d expected %0d", instret, exp_instret);
        else passes++;
        mret = 1'b0;
    endtask

    task automatic test_halt();
        set_pc(32'h50);
        load = 1'b1; PCSrc = 2'b00; halt_req = 1'b1;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (halted !== 1'b1 || PC !== 32'h50)
            $display("FAIL halt_enter: halted=%b PC=%h expected 1/00000050", halted, PC);
        else passes++;
        halt_req = 1'b0; PCSrc = 2'b01; ImmExt = 32'h10;
        for (int i = 0; i < 5; i++) begin
            trap_req = (i == 2);
            mret     = (i == 3);
            step();
            checks++;
            if (PC !== 32'h50 || halted !== 1'b1 || trap_taken !== 1'b0 || instret !== exp_instret)
                $display("FAIL halt_hold[%0d]: PC=%h halted=%b trap=%b instret=%0d expected 00000050/1/0/%0d",
                         i, PC, halted, trap_taken, instret, exp_instret);
            else passes++;
        end
        trap_req = 1'b0; mret = 1'b0;
        load = 1'b0; resume = 1'b1;
        step();
        checks++;
        if (halted !== 1'b0 || PC !== 32'h50)
            $display("FAIL resume: halted=%b PC=%h expected 0/00000050", halted, PC);
        else passes++;
        resume = 1'b0; load = 1'b1; PCSrc = 2'b00;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h54) $display("FAIL resume_adv: PC=%h expected 00000054", PC); else passes++;
        checks++;
        if (instret !== exp_instret) $display("FAIL resume_instret: instret=%0d expected %0d", instret, exp_instret);
        else passes++;
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++;
        if (PCPlus4 !== 32'h0) $display("FAIL wrap_pcplus4: PCPlus4=%h expected 00000000", PCPlus4); else passes++;
        load = 1'b1; PCSrc = 2'b00;
        step();
        exp_instret = exp_instret + 1;
        checks++;
        if (PC !== 32'h0) $display("FAIL wrap_pc: PC=%h expected 00000000", PC); else passes++;
    endtask

    task automatic test_reset_mid_trap();
        set_pc(32'h60);
        load = 1'b1; trap_req = 1'b1; areset = 1'b1;
        step();
        checks++;
        if (PC !== 32'h0 || epc !== 32'h0 || trap_taken !== 1'b0)
            $display("FAIL reset_trap: PC=%h epc=%h trap=%b expected 00000000/00000000/0", PC, epc, trap_taken);
        else passes++;
        checks++;
        if (instret !== 32'h0) $display("FAIL reset_trap_instret: instret=%0d expected 0", instret); else passes++;
        areset = 1'b0; trap_req = 1'b0; PCSrc = 2'b00;
        step();
        checks++;
        if (PC !== 32'h4 || instret !== 32'd1)
            $display("FAIL post_reset: PC=%h instret=%0d expected 00000004/1", PC, instret);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_trap_mret();
        test_halt();
        test_wrap();
        test_reset_mid_trap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
